// File: rtl/psram_qpi_ctrl_if.sv
// rtl/psram_qpi_ctrl_if.sv - single-beat request/response bus between the SoC bridge and the PSRAM controller
interface psram_qpi_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [23:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/psram_qpi_ctrl.sv
// rtl/psram_qpi_ctrl.sv - QPI PSRAM controller: 35h enter-QPI after reset, then EBh quad reads and 38h quad writes
module psram_qpi_ctrl #(
  parameter int CLK_DIV   = 1,
  parameter int READ_WAIT = 6,
  parameter int CE_HIGH   = 2
) (
  input  logic            clk,
  input  logic            reset,
  psram_qpi_ctrl_if.slave bus,
  output logic            sck,
  output logic            ce_n,
  output logic [3:0]      dio_o,
  output logic            dio_oe,
  input  logic [3:0]      dio_i
);

  localparam logic [2:0] INIT    = 3'd0;
  localparam logic [2:0] IDLE    = 3'd1;
  localparam logic [2:0] CMD     = 3'd2;
  localparam logic [2:0] ADDR    = 3'd3;
  localparam logic [2:0] WAIT    = 3'd4;
  localparam logic [2:0] RDATA   = 3'd5;
  localparam logic [2:0] WDATA   = 3'd6;
  localparam logic [2:0] RECOVER = 3'd7;

  localparam logic [7:0]  INIT_CMD  = 8'h35;
  localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0]  WAIT_LAST = 8'(READ_WAIT - 1);
  localparam logic [15:0] CE_LAST   = 16'(CE_HIGH - 1);

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic [7:0]  div_cnt;
  logic [7:0]  nib;
  logic [7:0]  next_nib;
  logic        last_nib;
  logic [15:0] rec_cnt;
  logic        wr;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic [2:0]  data_last;
  logic [31:0] rd_buf;
  logic [31:0] rd_merged;
  logic [4:0]  lane_idx;

  // Nibble driven for pulse n of a given phase; byte lanes go high nibble first.
  function automatic logic [3:0] nib_out(input logic [2:0] st, input logic [7:0] n,
                                         input logic w, input logic [23:0] a,
                                         input logic [31:0] d);
    logic [7:0] cmd_byte;
    logic [4:0] a_idx;
    logic [4:0] d_idx;
    cmd_byte = w ? 8'h38 : 8'hEB;
    a_idx    = 5'd20 - {n[2:0], 2'b00};
    d_idx    = {n[2:1], ~n[0], 2'b00};
    case (st)
      INIT:    return {3'b000, INIT_CMD[3'd7 - n[2:0]]};
      CMD:     return n[0] ? cmd_byte[3:0] : cmd_byte[7:4];
      ADDR:    return a[a_idx +: 4];
      WDATA:   return d[d_idx +: 4];
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic drives(input logic [2:0] st);
    return (st == INIT) || (st == CMD) || (st == ADDR) || (st == WDATA);
  endfunction

  assign lane_idx = {nib[2:1], ~nib[0], 2'b00};

  always_comb begin
    rd_merged = rd_buf;
    rd_merged[lane_idx +: 4] = dio_i;
  end

  // Phase sequencing evaluated at the end of each high phase.
  always_comb begin
    last_nib   = 1'b0;
    next_state = state;
    next_nib   = nib + 8'd1;
    case (state)
      INIT:         last_nib = (nib == 8'd7);
      CMD:          last_nib = (nib == 8'd1);
      ADDR:         last_nib = (nib == 8'd5);
      WAIT:         last_nib = (nib == WAIT_LAST);
      RDATA, WDATA: last_nib = (nib == {5'b0, data_last});
      default:      last_nib = 1'b0;
    endcase
    if (last_nib) begin
      next_nib = 8'd0;
      case (state)
        CMD:     next_state = ADDR;
        ADDR:    next_state = wr ? WDATA : ((READ_WAIT > 0) ? WAIT : RDATA);
        WAIT:    next_state = RDATA;
        default: next_state = RECOVER;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= INIT;
      ce_n           <= 1'b1;
      sck            <= 1'b0;
      dio_o          <= 4'h0;
      dio_oe         <= 1'b0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'h0;
      div_cnt        <= 8'd0;
      nib            <= 8'd0;
      rec_cnt        <= 16'd0;
      wr             <= 1'b0;
      addr           <= 24'h0;
      wdata          <= 32'h0;
      data_last      <= 3'd0;
      rd_buf         <= 32'h0;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            wr            <= bus.req_write;
            addr          <= bus.req_addr;
            wdata         <= bus.req_wdata;
            case (bus.req_size)
              2'd0:    data_last <= 3'd1;
              2'd1:    data_last <= 3'd3;
              default: data_last <= 3'd7;
            endcase
            rd_buf        <= 32'h0;
            bus.req_ready <= 1'b0;
            state         <= CMD;
            ce_n          <= 1'b0;
            sck           <= 1'b0;
            div_cnt       <= 8'd0;
            nib           <= 8'd0;
            dio_o         <= bus.req_write ? 4'h3 : 4'hE;
            dio_oe        <= 1'b1;
          end
        end
        RECOVER: begin
          if (rec_cnt == CE_LAST) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
          end else begin
            rec_cnt <= rec_cnt + 16'd1;
          end
        end
        default: begin
          if (ce_n) begin
            // Only INIT arrives here with ce_n high: open the SPI enter-QPI frame.
            ce_n    <= 1'b0;
            sck     <= 1'b0;
            div_cnt <= 8'd0;
            nib     <= 8'd0;
            dio_o   <= {3'b000, INIT_CMD[7]};
            dio_oe  <= 1'b1;
          end else if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= 8'd0;
            if (!sck) begin
              sck <= 1'b1;
            end else begin
              sck   <= 1'b0;
              state <= next_state;
              nib   <= next_nib;
              if (state == RDATA) rd_buf <= rd_merged;
              if (next_state == RECOVER) begin
                ce_n    <= 1'b1;
                dio_oe  <= 1'b0;
                dio_o   <= 4'h0;
                rec_cnt <= 16'd0;
                if (state != INIT) begin
                  bus.resp_valid <= 1'b1;
                  if (!wr) bus.resp_rdata <= rd_merged;
                end
              end else begin
                dio_o  <= nib_out(next_state, next_nib, wr, addr, wdata);
                dio_oe <= drives(next_state);
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psram_qpi_ctrl.sv
// tb/tb_psram_qpi_ctrl.sv - directed bench for psram_qpi_ctrl at CLK_DIV=1 and CLK_DIV=3 against a PSRAM model
module tb_psram_qpi_ctrl;
  localparam int READ_WAIT = 6;
  localparam int CE_HIGH   = 2;
  localparam int BOUND     = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        rv  [2];
  logic        rw  [2];
  logic [23:0] ra  [2];
  logic [1:0]  rs  [2];
  logic [31:0] rwd [2];
  logic        rdy [2];
  logic        rsp [2];
  logic [31:0] rdat[2];
  logic        sck_w[2];
  logic        ce_w [2];
  logic        oe_w [2];
  logic [3:0]  do_w [2];
  logic [3:0]  din  [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 2; g++) begin : u
    psram_qpi_ctrl_if bus();
    assign bus.req_valid = rv[g];
    assign bus.req_write = rw[g];
    assign bus.req_addr  = ra[g];
    assign bus.req_size  = rs[g];
    assign bus.req_wdata = rwd[g];
    assign rdy[g]  = bus.req_ready;
    assign rsp[g]  = bus.resp_valid;
    assign rdat[g] = bus.resp_rdata;
    psram_qpi_ctrl #(.CLK_DIV(g == 0 ? 1 : 3), .READ_WAIT(READ_WAIT), .CE_HIGH(CE_HIGH)) dut (
      .clk(clk), .reset(rst[g]), .bus(bus),
      .sck(sck_w[g]), .ce_n(ce_w[g]), .dio_o(do_w[g]), .dio_oe(oe_w[g]), .dio_i(din[g])
    );
  end

  // PSRAM model plus pin monitor, evaluated mid-cycle on both instances.
  logic [7:0] mem  [2][512];
  int         mcnt [2];
  logic [3:0] mnib [2][64];
  logic       moe  [2][64];
  logic       sck_q[2];
  logic       ce_q [2];
  logic [8:0] m_addr;
  int         m_j;

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (ce_q[g] && !ce_w[g]) mcnt[g] = 0;
      if (!ce_w[g] && sck_w[g] && !sck_q[g]) begin
        if (mcnt[g] < 64) begin
          mnib[g][mcnt[g]] = do_w[g];
          moe[g][mcnt[g]]  = oe_w[g];
        end
        if (mcnt[g] >= 8 && mcnt[g] < 16 && {mnib[g][0], mnib[g][1]} == 8'h38) begin
          m_j    = mcnt[g] - 8;
          m_addr = {mnib[g][5][0], mnib[g][6], mnib[g][7]} + 9'(m_j / 2);
          if (m_j % 2 == 0) mem[g][m_addr][7:4] = do_w[g];
          else              mem[g][m_addr][3:0] = do_w[g];
        end
        mcnt[g]++;
      end
      if (!ce_w[g] && !sck_w[g] && sck_q[g] && {mnib[g][0], mnib[g][1]} == 8'hEB
          && mcnt[g] >= 8 + READ_WAIT) begin
        m_j    = mcnt[g] - 8 - READ_WAIT;
        m_addr = {mnib[g][5][0], mnib[g][6], mnib[g][7]} + 9'(m_j / 2);
        din[g] = (m_j % 2 == 0) ? mem[g][m_addr][7:4] : mem[g][m_addr][3:0];
      end
      sck_q[g] = sck_w[g];
      ce_q[g]  = ce_w[g];
    end
  end

  // Called at a negedge; returns at the negedge of the response cycle.
  task automatic transact(input int g, input logic w, input logic [23:0] a, input logic [1:0] s,
                          input logic [31:0] d, output int hs_abs, output int rsp_cyc,
                          output logic [31:0] rdata, output logic ce_at_rsp);
    int n;
    n = 0;
    rsp_cyc = -1; rdata = 32'hx; ce_at_rsp = 1'bx;
    while (rdy[g] !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
    if (n >= BOUND) begin
      checks++; errors++;
      $display("FAIL ready_timeout inst %0d", g);
    end
    rv[g] = 1'b1; rw[g] = w; ra[g] = a; rs[g] = s; rwd[g] = d;
    hs_abs = cyc;
    @(negedge clk);
    rv[g] = 1'b0;
    n = 1;
    while (n < BOUND) begin
      if (rsp[g] === 1'b1) begin
        rsp_cyc = n; rdata = rdat[g]; ce_at_rsp = ce_w[g];
        break;
      end
      @(negedge clk);
      n++;
    end
    if (rsp_cyc < 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout inst %0d", g);
    end
  endtask

  task automatic test_reset();
    int n;
    logic [7:0] exp_init;
    exp_init = 8'h35;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++; if (ce_w[g] !== 1'b1)   begin errors++; $display("FAIL rst_ce_n inst %0d got %b exp 1", g, ce_w[g]); end
      checks++; if (sck_w[g] !== 1'b0)  begin errors++; $display("FAIL rst_sck inst %0d got %b exp 0", g, sck_w[g]); end
      checks++; if (oe_w[g] !== 1'b0)   begin errors++; $display("FAIL rst_dio_oe inst %0d got %b exp 0", g, oe_w[g]); end
      checks++; if (do_w[g] !== 4'h0)   begin errors++; $display("FAIL rst_dio_o inst %0d got %h exp 0", g, do_w[g]); end
      checks++; if (rdy[g] !== 1'b0)    begin errors++; $display("FAIL rst_ready inst %0d got %b exp 0", g, rdy[g]); end
      checks++; if (rsp[g] !== 1'b0)    begin errors++; $display("FAIL rst_resp_valid inst %0d got %b exp 0", g, rsp[g]); end
      checks++; if (rdat[g] !== 32'h0)  begin errors++; $display("FAIL rst_rdata inst %0d got %h exp 0", g, rdat[g]); end
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    n = 0;
    while (ce_w[0] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    while (ce_w[0] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++; if (n >= 100) begin errors++; $display("FAIL init_timeout got %0d cycles", n); end
    checks++; if (mcnt[0] !== 8) begin errors++; $display("FAIL init_pulses got %0d exp 8", mcnt[0]); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mnib[0][i] !== {3'b000, exp_init[7-i]} || moe[0][i] !== 1'b1) begin
        errors++;
        $display("FAIL init_bit%0d got dio %h oe %b exp dio %h oe 1", i, mnib[0][i], moe[0][i], exp_init[7-i]);
      end
    end
    checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL init_ready_c0 got %b exp 0", rdy[0]); end
    @(negedge clk);
    checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL init_ready_c1 got %b exp 0", rdy[0]); end
    @(negedge clk);
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL init_ready_c2 got %b exp 1", rdy[0]); end
  endtask

  task automatic test_write4();
    int hs, rc;
    logic [31:0] rd;
    logic ce;
    logic [3:0] exp_nib [16];
    exp_nib = '{4'h3, 4'h8, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0,
                4'hA, 4'hA, 4'hB, 4'hB, 4'hC, 4'hC, 4'hD, 4'hD};
    transact(0, 1'b1, 24'h000100, 2'd2, 32'hDDCCBBAA, hs, rc, rd, ce);
    checks++; if (rc !== 33)    begin errors++; $display("FAIL wr4_resp_cycle got %0d exp 33", rc); end
    checks++; if (ce !== 1'b1)  begin errors++; $display("FAIL wr4_ce_at_resp got %b exp 1", ce); end
    checks++; if (mcnt[0] !== 16) begin errors++; $display("FAIL wr4_pulses got %0d exp 16", mcnt[0]); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mnib[0][i] !== exp_nib[i] || moe[0][i] !== 1'b1) begin
        errors++;
        $display("FAIL wr4_nib%0d got %h oe %b exp %h oe 1", i, mnib[0][i], moe[0][i], exp_nib[i]);
      end
    end
    @(negedge clk);
    checks++; if (rsp[0] !== 1'b0) begin errors++; $display("FAIL wr4_resp_pulse got %b exp 0", rsp[0]); end
  endtask

  task automatic test_read4();
    int hs, rc;
    logic [31:0] rd;
    logic ce;
    logic [3:0] exp_nib [8];
    exp_nib = '{4'hE, 4'hB, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
    transact(0, 1'b0, 24'h000100, 2'd2, 32'h0, hs, rc, rd, ce);
    checks++; if (rc !== 45)           begin errors++; $display("FAIL rd4_resp_cycle got %0d exp 45", rc); end
    checks++; if (rd !== 32'hDDCCBBAA) begin errors++; $display("FAIL rd4_rdata got %h exp DDCCBBAA", rd); end
    checks++; if (ce !== 1'b1)         begin errors++; $display("FAIL rd4_ce_at_resp got %b exp 1", ce); end
    checks++; if (mcnt[0] !== 22)      begin errors++; $display("FAIL rd4_pulses got %0d exp 22", mcnt[0]); end
    for (int i = 0; i < 22; i++) begin
      checks++;
      if (i < 8) begin
        if (mnib[0][i] !== exp_nib[i] || moe[0][i] !== 1'b1) begin
          errors++;
          $display("FAIL rd4_nib%0d got %h oe %b exp %h oe 1", i, mnib[0][i], moe[0][i], exp_nib[i]);
        end
      end else if (moe[0][i] !== 1'b0) begin
        errors++;
        $display("FAIL rd4_released%0d got oe %b exp 0", i, moe[0][i]);
      end
    end
  endtask

  task automatic test_read1();
    int hs, rc;
    logic [31:0] rd;
    logic ce;
    transact(0, 1'b0, 24'h000102, 2'd0, 32'h0, hs, rc, rd, ce);
    checks++; if (rc !== 33)           begin errors++; $display("FAIL rd1_resp_cycle got %0d exp 33", rc); end
    checks++; if (rd !== 32'h000000CC) begin errors++; $display("FAIL rd1_rdata got %h exp 000000CC", rd); end
    checks++; if (mcnt[0] !== 16)      begin errors++; $display("FAIL rd1_pulses got %0d exp 16", mcnt[0]); end
  endtask

  task automatic test_back_to_back();
    int hs1, rc1, hs2, rc2;
    logic [31:0] rd1, rd2;
    logic ce1, ce2;
    transact(0, 1'b1, 24'h000010, 2'd1, 32'h0000BEEF, hs1, rc1, rd1, ce1);
    transact(0, 1'b0, 24'h000010, 2'd2, 32'h0, hs2, rc2, rd2, ce2);
    checks++; if (rc1 !== 25)            begin errors++; $display("FAIL b2b_wr2_cycle got %0d exp 25", rc1); end
    checks++; if (rd1 !== 32'h000000CC)  begin errors++; $display("FAIL b2b_rdata_held got %h exp 000000CC", rd1); end
    checks++; if (hs2 - (hs1 + rc1) !== CE_HIGH) begin
      errors++; $display("FAIL b2b_gap got %0d exp %0d", hs2 - (hs1 + rc1), CE_HIGH);
    end
    checks++; if (rc2 !== 45)            begin errors++; $display("FAIL b2b_rd4_cycle got %0d exp 45", rc2); end
    checks++; if (rd2[15:0] !== 16'hBEEF) begin errors++; $display("FAIL b2b_rdata_lo got %h exp BEEF", rd2[15:0]); end
    checks++; if (rd2 !== 32'h0000BEEF)  begin errors++; $display("FAIL b2b_rdata got %h exp 0000BEEF", rd2); end
  endtask

  task automatic test_size3();
    int hs, rc;
    logic [31:0] rd;
    logic ce;
    transact(0, 1'b0, 24'h000100, 2'd3, 32'h0, hs, rc, rd, ce);
    checks++; if (rc !== 45)           begin errors++; $display("FAIL sz3_resp_cycle got %0d exp 45", rc); end
    checks++; if (rd !== 32'hDDCCBBAA) begin errors++; $display("FAIL sz3_rdata got %h exp DDCCBBAA", rd); end
  endtask

  task automatic test_reset_mid();
    int hs, rc, n;
    logic [31:0] rd;
    logic ce, saw;
    transact(1, 1'b1, 24'h000040, 2'd2, 32'h12345678, hs, rc, rd, ce);
    checks++; if (rc !== 97) begin errors++; $display("FAIL div3_wr4_cycle got %0d exp 97", rc); end
    n = 0;
    while (rdy[1] !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
    rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 24'h000040; rs[1] = 2'd2;
    @(negedge clk);
    rv[1] = 1'b0;
    saw = 1'b0;
    repeat (19) begin @(negedge clk); if (rsp[1] === 1'b1) saw = 1'b1; end
    checks++; if (ce_w[1] !== 1'b0) begin errors++; $display("FAIL mid_ce_active got %b exp 0", ce_w[1]); end
    rst[1] = 1'b1;
    #1;
    checks++; if (ce_w[1] !== 1'b1)  begin errors++; $display("FAIL mid_ce_async got %b exp 1", ce_w[1]); end
    checks++; if (sck_w[1] !== 1'b0) begin errors++; $display("FAIL mid_sck got %b exp 0", sck_w[1]); end
    checks++; if (oe_w[1] !== 1'b0)  begin errors++; $display("FAIL mid_dio_oe got %b exp 0", oe_w[1]); end
    repeat (3) begin @(negedge clk); if (rsp[1] === 1'b1) saw = 1'b1; end
    rst[1] = 1'b0;
    n = 0;
    while (rdy[1] !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      if (rsp[1] === 1'b1) saw = 1'b1;
      n++;
    end
    checks++; if (n >= BOUND)     begin errors++; $display("FAIL mid_reinit_timeout got %0d cycles", n); end
    checks++; if (saw !== 1'b0)   begin errors++; $display("FAIL mid_no_resp got %b exp 0", saw); end
    checks++; if (mcnt[1] !== 8)  begin errors++; $display("FAIL mid_reinit_pulses got %0d exp 8", mcnt[1]); end
    transact(1, 1'b0, 24'h000040, 2'd2, 32'h0, hs, rc, rd, ce);
    checks++; if (rc !== 133)          begin errors++; $display("FAIL div3_rd4_cycle got %0d exp 133", rc); end
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL div3_rd4_rdata got %h exp 12345678", rd); end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; rv[g] = 1'b0; rw[g] = 1'b0; ra[g] = 24'h0; rs[g] = 2'd0; rwd[g] = 32'h0;
      din[g] = 4'h0; mcnt[g] = 0; sck_q[g] = 1'b0; ce_q[g] = 1'b1;
      for (int i = 0; i < 64; i++) begin mnib[g][i] = 4'h0; moe[g][i] = 1'b0; end
      for (int i = 0; i < 512; i++) mem[g][i] = 8'h00;
    end
    test_reset();
    test_write4();
    test_read4();
    test_read1();
    test_back_to_back();
    test_size3();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
